gsm_buf_alloc: RTL and testbench

//   Free-cell allocator for the gsm_ram central memory. Keeps a FIFO free list of
//   all 2**AWIDTH cell addresses, hands one out per accepted ingress request (drives
//   gsm_ram i_wr_addr), and takes back addresses released by gsm_ram
//   (o_buf_free / o_buf_free_addr). Sits directly upstream of gsm_ram's write port.

---
 rtl/gsm_buf_alloc.sv | 133 +++++++++++++
 tb/tb_gsm_buf_alloc.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gsm_buf_alloc.sv
// Free-cell allocator for the gsm_ram central memory: a FIFO free list of every
// cell address. It offers the list head (show-ahead) and takes back released cells.
module gsm_buf_alloc #(
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              i_alloc_req,
    output logic              o_alloc_valid,
    output logic [AWIDTH-1:0] o_alloc_addr,
    input  logic              i_free_en,
    input  logic [AWIDTH-1:0] i_free_addr,
    output logic [AWIDTH:0]   o_free_cnt,
    output logic              o_init_done,
    output logic              o_err
);

    localparam int                DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]   FULL  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST  = AWIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t state_reg, state_next;

    logic [AWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] init_cnt_reg;
    logic [AWIDTH-1:0] rd_ptr_reg;
    logic [AWIDTH-1:0] wr_ptr_reg;
    logic [AWIDTH-1:0] head_reg;
    logic [AWIDTH:0]   cnt_reg;
    logic              err_reg;

    logic              running;
    logic              pop;
    logic              push;
    logic              bad_free;
    logic [AWIDTH-1:0] rd_ptr_next;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [AWIDTH-1:0] wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_INIT && init_cnt_reg == LAST) begin
            state_next = ST_RUN;
        end
        if (clr) begin
            state_next = ST_INIT;
        end
    end

    // A push at full is only legal when a pop frees a slot in the same cycle.
    always_comb begin
        running     = (state_reg == ST_RUN);
        pop         = running && (cnt_reg != '0) && i_alloc_req;
        push        = running && i_free_en && ((cnt_reg != FULL) || pop);
        bad_free    = i_free_en && !push;
        rd_ptr_next = rd_ptr_reg + {{(AWIDTH-1){1'b0}}, pop};
        wr_en       = !running || push;
        wr_addr     = running ? wr_ptr_reg  : init_cnt_reg;
        wr_data     = running ? i_free_addr : init_cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_reg <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            head_reg     <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
        end else if (clr) begin
            init_cnt_reg <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            head_reg     <= '0;
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (!running) begin
                // The rebuilt list always starts at cell 0, so the head is known.
                init_cnt_reg <= init_cnt_reg + 1'b1;
                cnt_reg      <= cnt_reg + 1'b1;
                head_reg     <= '0;
            end else begin
                rd_ptr_reg <= rd_ptr_next;
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop && !push) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end else if (push && !pop) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                // Prefetch the next head; forward a same-cycle push into the slot being read.
                if (push && (wr_ptr_reg == rd_ptr_next)) begin
                    head_reg <= i_free_addr;
                end else begin
                    head_reg <= mem[rd_ptr_next];
                end
            end
            if (bad_free) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign o_alloc_valid = running && (cnt_reg != '0);
    assign o_alloc_addr  = head_reg;
    assign o_free_cnt    = cnt_reg;
    assign o_init_done   = running;
    assign o_err         = err_reg;

endmodule

// File: tb/tb_gsm_buf_alloc.sv
// Directed bench for gsm_buf_alloc (AWIDTH=9): init, allocate, drain/refill,
// simultaneous pop+push, illegal frees, clr re-init and asynchronous reset.
module tb_gsm_buf_alloc;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       i_alloc_req;
    logic       o_alloc_valid;
    logic [8:0] o_alloc_addr;
    logic       i_free_en;
    logic [8:0] i_free_addr;
    logic [9:0] o_free_cnt;
    logic       o_init_done;
    logic       o_err;

    int tests_run    = 0;
    int tests_failed = 0;

    gsm_buf_alloc #(.AWIDTH(9)) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .i_alloc_req   (i_alloc_req),
        .o_alloc_valid (o_alloc_valid),
        .o_alloc_addr  (o_alloc_addr),
        .i_free_en     (i_free_en),
        .i_free_addr   (i_free_addr),
        .o_free_cnt    (o_free_cnt),
        .o_init_done   (o_init_done),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!o_init_done && n < 600) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n), 32'd512);
    endtask

    initial begin
        int bad;
        logic [8:0] exp_addr;

        rst = 1'b1; clr = 1'b0; i_alloc_req = 1'b0; i_free_en = 1'b0; i_free_addr = '0;
        cyc();
        chk("rst_cnt",   32'(o_free_cnt),    32'd0);
        chk("rst_valid", 32'(o_alloc_valid), 32'd0);
        chk("rst_done",  32'(o_init_done),   32'd0);
        chk("rst_err",   32'(o_err),         32'd0);
        rst = 1'b0;

        // 1: initialisation
        wait_init("init_cycles");
        chk("init_cnt",   32'(o_free_cnt),    32'd512);
        chk("init_valid", 32'(o_alloc_valid), 32'd1);
        chk("init_addr",  32'(o_alloc_addr),  32'd0);
        chk("init_err",   32'(o_err),         32'd0);
        $display("[TB] init: cnt=%0d head=0x%0h", o_free_cnt, o_alloc_addr);

        // 2: three allocations
        i_alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("alloc3_valid", 32'(o_alloc_valid), 32'd1);
            chk("alloc3_addr",  32'(o_alloc_addr),  32'(i));
            cyc();
        end
        i_alloc_req = 1'b0;
        chk("alloc3_cnt",  32'(o_free_cnt),   32'd509);
        chk("alloc3_head", 32'(o_alloc_addr), 32'd3);
        $display("[TB] alloc x3: cnt=%0d head=0x%0h", o_free_cnt, o_alloc_addr);

        // 3: drain, then refill two cells from empty
        i_alloc_req = 1'b1;
        bad = 0;
        for (int i = 3; i < 512; i++) begin
            if (!o_alloc_valid || o_alloc_addr != 9'(i)) bad++;
            cyc();
        end
        i_alloc_req = 1'b0;
        chk("drain_seq",   32'(bad),           32'd0);
        chk("drain_cnt",   32'(o_free_cnt),    32'd0);
        chk("drain_valid", 32'(o_alloc_valid), 32'd0);
        i_free_en = 1'b1; i_free_addr = 9'h1A5;
        chk("nobypass_valid", 32'(o_alloc_valid), 32'd0);
        cyc();
        i_free_addr = 9'h007;
        chk("refill_valid", 32'(o_alloc_valid), 32'd1);
        chk("refill_addr0", 32'(o_alloc_addr),  32'h1A5);
        cyc();
        i_free_en = 1'b0; i_alloc_req = 1'b1;
        chk("refill_cnt",   32'(o_free_cnt),   32'd2);
        chk("refill_pop0",  32'(o_alloc_addr), 32'h1A5);
        cyc();
        chk("refill_pop1",  32'(o_alloc_addr), 32'h007);
        cyc();
        i_alloc_req = 1'b0;
        chk("refill_empty_cnt",   32'(o_free_cnt),    32'd0);
        chk("refill_empty_valid", 32'(o_alloc_valid), 32'd0);
        $display("[TB] drain/refill: cnt=%0d", o_free_cnt);

        // 4: simultaneous pop+push at count 10
        i_free_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_free_addr = 9'h100 + 9'(i);
            cyc();
        end
        i_free_en = 1'b0;
        chk("pp_pre_cnt", 32'(o_free_cnt), 32'd10);
        i_alloc_req = 1'b1; i_free_en = 1'b1; i_free_addr = 9'h0FF;
        for (int i = 0; i < 5; i++) begin
            chk("pp_addr", 32'(o_alloc_addr), 32'h100 + 32'(i));
            cyc();
        end
        i_free_en = 1'b0;
        chk("pp_cnt", 32'(o_free_cnt), 32'd10);
        for (int i = 0; i < 10; i++) begin
            exp_addr = (i < 5) ? 9'h105 + 9'(i) : 9'h0FF;
            chk("pp_order", 32'(o_alloc_addr), 32'(exp_addr));
            cyc();
        end
        i_alloc_req = 1'b0;
        chk("pp_end_cnt", 32'(o_free_cnt), 32'd0);
        $display("[TB] pop+push: cnt=%0d", o_free_cnt);

        // clr from empty, full list rebuilt
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        wait_init("reinit_cycles");
        chk("reinit_cnt",  32'(o_free_cnt),   32'd512);
        chk("reinit_addr", 32'(o_alloc_addr), 32'd0);

        // 5: illegal free at full, then legal free at full with pop
        i_free_en = 1'b1; i_free_addr = 9'h010;
        cyc();
        i_free_en = 1'b0;
        chk("full_free_cnt", 32'(o_free_cnt), 32'd512);
        chk("full_free_err", 32'(o_err),      32'd1);
        cyc();
        chk("err_sticky", 32'(o_err), 32'd1);
        i_alloc_req = 1'b1; i_free_en = 1'b1; i_free_addr = 9'h010;
        chk("full_pp_addr", 32'(o_alloc_addr), 32'd0);
        cyc();
        i_alloc_req = 1'b0; i_free_en = 1'b0;
        chk("full_pp_cnt",  32'(o_free_cnt),   32'd512);
        chk("full_pp_head", 32'(o_alloc_addr), 32'd1);
        $display("[TB] illegal free: err=%0d cnt=%0d", o_err, o_free_cnt);

        // 6: clr at count 200, free during INIT, re-init
        i_alloc_req = 1'b1;
        repeat (312) cyc();
        i_alloc_req = 1'b0;
        chk("pre_clr_cnt", 32'(o_free_cnt), 32'd200);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("clr_cnt",   32'(o_free_cnt),    32'd0);
        chk("clr_valid", 32'(o_alloc_valid), 32'd0);
        chk("clr_err",   32'(o_err),         32'd0);
        chk("clr_done",  32'(o_init_done),   32'd0);
        i_free_en = 1'b1; i_free_addr = 9'h1FF;
        cyc();
        i_free_en = 1'b0;
        chk("init_free_err", 32'(o_err),      32'd1);
        chk("init_free_cnt", 32'(o_free_cnt), 32'd1);
        bad = 0;
        while (!o_init_done && bad < 600) begin
            cyc();
            bad++;
        end
        chk("clr_init_cycles", 32'(bad),        32'd511);
        chk("clr_init_cnt",    32'(o_free_cnt), 32'd512);
        i_alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("clr_list_addr", 32'(o_alloc_addr), 32'(i));
            cyc();
        end
        i_alloc_req = 1'b0;
        $display("[TB] clr re-init: cnt=%0d err=%0d", o_free_cnt, o_err);

        // asynchronous reset mid-cycle
        #3;
        rst = 1'b1;
        #1;
        chk("async_cnt",   32'(o_free_cnt),    32'd0);
        chk("async_valid", 32'(o_alloc_valid), 32'd0);
        chk("async_done",  32'(o_init_done),   32'd0);
        chk("async_err",   32'(o_err),         32'd0);
        chk("async_addr",  32'(o_alloc_addr),  32'd0);
        #2;
        rst = 1'b0;
        cyc();
        chk("post_rst_done", 32'(o_init_done), 32'd0);
        chk("post_rst_cnt",  32'(o_free_cnt),  32'd1);
        $display("[TB] async reset: cnt=%0d", o_free_cnt);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
